pending_prio_encoder: RTL and testbench



---
 rtl/encoder_pkg.sv | 15 +
 rtl/prio_encoder_core.sv | 27 ++
 rtl/pending_prio_encoder.sv | 59 +++++
 tb/tb_pending_prio_encoder.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/encoder_pkg.sv
// Shared constants and helpers for the priority-encoder family.
package encoder_pkg;

    localparam bit PRIO_HIGH_FIRST = 1'b1;
    localparam bit PRIO_LOW_FIRST  = 1'b0;

    // Index width needed to address n items (n >= 2).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/prio_encoder_core.sv
// Combinational fixed-priority encoder: vector in, winning index and any-set out.
module prio_encoder_core
    import encoder_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit PRIO_HIGH = PRIO_HIGH_FIRST,
    localparam int IDX_W    = clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Later iterations overwrite earlier ones, so scan order sets the winner.
    always_comb begin
        idx = '0;
        any = |vec;
        if (PRIO_HIGH) begin
            for (int i = 0; i < WIDTH; i++)
                if (vec[i]) idx = IDX_W'(i);
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--)
                if (vec[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/pending_prio_encoder.sv
// Sticky pending-request register with prioritised index output and valid/ready pop.
module pending_prio_encoder
    import encoder_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit PRIO_HIGH = PRIO_HIGH_FIRST,
    localparam int IDX_W    = clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] req_in,
    input  logic             clr_all,
    output logic             out_valid,
    output logic [IDX_W-1:0] out_idx,
    input  logic             out_ready,
    output logic [WIDTH-1:0] pending,
    output logic [IDX_W:0]   pend_cnt,
    output logic             overflow
);

    logic [WIDTH-1:0] pend_q;
    logic [WIDTH-1:0] pop_mask;
    logic             ovf_q;

    prio_encoder_core #(
        .WIDTH    (WIDTH),
        .PRIO_HIGH(PRIO_HIGH)
    ) u_enc (
        .vec(pend_q),
        .idx(out_idx),
        .any(out_valid)
    );

    assign pop_mask = (out_valid && out_ready) ? (WIDTH'(1) << out_idx) : '0;

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < WIDTH; i++)
            pend_cnt = pend_cnt + (IDX_W+1)'(pend_q[i]);
    end

    // A request landing on the bit being popped re-arms it rather than overflowing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else if (clr_all) begin
            pend_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pend_q <= (pend_q & ~pop_mask) | req_in;
            ovf_q  <= |(req_in & pend_q & ~pop_mask);
        end
    end

    assign pending  = pend_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_pending_prio_encoder.sv
// Directed bench: high-priority, low-priority and WIDTH=5 instances side by side.
module tb_pending_prio_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] req_ab;
    logic [4:0] req_c;
    logic       clr_all;
    logic       out_ready;

    logic       a_valid, b_valid, c_valid;
    logic [2:0] a_idx, b_idx, c_idx;
    logic [7:0] a_pend, b_pend;
    logic [4:0] c_pend;
    logic [3:0] a_cnt, b_cnt, c_cnt;
    logic       a_ovf, b_ovf, c_ovf;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pending_prio_encoder #(.WIDTH(8), .PRIO_HIGH(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_in(req_ab), .clr_all(clr_all),
        .out_valid(a_valid), .out_idx(a_idx), .out_ready(out_ready),
        .pending(a_pend), .pend_cnt(a_cnt), .overflow(a_ovf));

    pending_prio_encoder #(.WIDTH(8), .PRIO_HIGH(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_in(req_ab), .clr_all(clr_all),
        .out_valid(b_valid), .out_idx(b_idx), .out_ready(out_ready),
        .pending(b_pend), .pend_cnt(b_cnt), .overflow(b_ovf));

    pending_prio_encoder #(.WIDTH(5), .PRIO_HIGH(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .req_in(req_c), .clr_all(clr_all),
        .out_valid(c_valid), .out_idx(c_idx), .out_ready(out_ready),
        .pending(c_pend), .pend_cnt(c_cnt), .overflow(c_ovf));

    typedef struct {
        logic [7:0] req;
        logic       clr;
        logic       rdy;
        logic       valid;
        logic [2:0] idx;
        logic [7:0] pend;
        logic [3:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t tbl[20];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic v, input logic [2:0] i,
                         input logic [7:0] p, input logic [3:0] c, input logic o);
        chk({tag, " valid"},    64'(a_valid), 64'(v));
        chk({tag, " idx"},      64'(a_idx),   64'(i));
        chk({tag, " pending"},  64'(a_pend),  64'(p));
        chk({tag, " pend_cnt"}, 64'(a_cnt),   64'(c));
        chk({tag, " overflow"}, 64'(a_ovf),   64'(o));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            req    clr   rdy   valid idx   pend   cnt   ovf
        tbl[0]  = '{8'h20, 1'b0, 1'b0, 1'b1, 3'd5, 8'h20, 4'd1, 1'b0};
        tbl[1]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0};
        tbl[2]  = '{8'h91, 1'b0, 1'b1, 1'b1, 3'd7, 8'h91, 4'd3, 1'b0};
        tbl[3]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd4, 8'h11, 4'd2, 1'b0};
        tbl[4]  = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h01, 4'd1, 1'b0};
        tbl[5]  = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0};
        tbl[6]  = '{8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 4'd1, 1'b0};
        tbl[7]  = '{8'h08, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 4'd1, 1'b1};
        tbl[8]  = '{8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'h08, 4'd1, 1'b0};
        tbl[9]  = '{8'h08, 1'b0, 1'b1, 1'b1, 3'd3, 8'h08, 4'd1, 1'b0};
        tbl[10] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0};
        tbl[11] = '{8'h02, 1'b0, 1'b0, 1'b1, 3'd1, 8'h02, 4'd1, 1'b0};
        tbl[12] = '{8'h40, 1'b0, 1'b0, 1'b1, 3'd6, 8'h42, 4'd2, 1'b0};
        tbl[13] = '{8'h00, 1'b0, 1'b1, 1'b1, 3'd1, 8'h02, 4'd1, 1'b0};
        tbl[14] = '{8'h00, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0};
        tbl[15] = '{8'hFF, 1'b0, 1'b0, 1'b1, 3'd7, 8'hFF, 4'd8, 1'b0};
        tbl[16] = '{8'h01, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0};
        tbl[17] = '{8'hFF, 1'b0, 1'b0, 1'b1, 3'd7, 8'hFF, 4'd8, 1'b0};
        tbl[18] = '{8'hFF, 1'b0, 1'b1, 1'b1, 3'd7, 8'hFF, 4'd8, 1'b1};
        tbl[19] = '{8'h00, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 4'd0, 1'b0};

        // Reset with activity on the inputs, which must be ignored.
        rst_n = 1'b0; req_ab = 8'hFF; req_c = 5'h1F; clr_all = 1'b0; out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk_a($sformatf("reset%0d", k), 1'b0, 3'd0, 8'h00, 4'd0, 1'b0);
        end

        rst_n = 1'b1; req_c = '0;
        for (int r = 0; r < 20; r++) begin
            req_ab = tbl[r].req; clr_all = tbl[r].clr; out_ready = tbl[r].rdy;
            step();
            chk_a($sformatf("row%0d", r), tbl[r].valid, tbl[r].idx, tbl[r].pend,
                  tbl[r].cnt, tbl[r].ovf);
        end

        // Reset in the middle of activity drops everything, with no pop.
        req_ab = 8'hC3; req_c = 5'h15; clr_all = 1'b0; out_ready = 1'b0;
        step();
        chk("pre_reset pending", 64'(a_pend), 64'h00C3);
        rst_n = 1'b0; req_ab = 8'hFF; out_ready = 1'b1;
        step();
        chk_a("midreset", 1'b0, 3'd0, 8'h00, 4'd0, 1'b0);
        chk("midreset c pending", 64'(c_pend), 64'h0);

        // Priority direction: high-first vs low-first on the same vector.
        rst_n = 1'b1; req_ab = 8'h91; req_c = '0; out_ready = 1'b1;
        step();
        req_ab = 8'h00;
        chk("prio a idx0", 64'(a_idx), 64'd7);
        chk("prio b idx0", 64'(b_idx), 64'd0);
        chk("prio b cnt0", 64'(b_cnt), 64'd3);
        step();
        chk("prio a idx1", 64'(a_idx), 64'd4);
        chk("prio b idx1", 64'(b_idx), 64'd4);
        chk("prio b pend1", 64'(b_pend), 64'h90);
        step();
        chk("prio a idx2", 64'(a_idx), 64'd0);
        chk("prio b idx2", 64'(b_idx), 64'd7);
        step();
        chk("prio a valid3", 64'(a_valid), 64'd0);
        chk("prio b valid3", 64'(b_valid), 64'd0);

        // Non-power-of-two width: full vector drains 4..0, count starts at 5.
        req_c = 5'h1F;
        step();
        req_c = '0;
        chk("w5 cnt", 64'(c_cnt), 64'd5);
        for (int k = 4; k >= 0; k--) begin
            chk($sformatf("w5 valid%0d", k), 64'(c_valid), 64'd1);
            chk($sformatf("w5 idx%0d", k), 64'(c_idx), 64'(k));
            step();
        end
        chk("w5 drained", 64'(c_valid), 64'd0);
        chk("w5 idx idle", 64'(c_idx), 64'd0);
        chk("w5 overflow", 64'(c_ovf), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
